hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage in-order RISC-V core.
- Generates stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage forwarding selects.
- Owns the data-memory request/acknowledge handshake FSM, holding the pipeline while a multi-cycle data access is outstanding.
- Sits beside the datapath; every pipeline register takes its enable/clear from this block.

Parameters:
- MEM_TIMEOUT, 64, max cycles in WAIT without dmemAck before error; legal range 2..65535.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1d, rs2d  in  5 each  source registers, ID stage.
- rs1e, rs2e, rde  in  5 each  sources and destination, EX stage.
- rsltSrce  in  2  result source, EX stage; 2'b01 = load.
- pcSrce  in  1  branch/jump taken, resolved in EX.
- regWrtm, rdm  in  1, 5  write enable and destination, MEM stage.
- regWrtw, rdw  in  1, 5  write enable and destination, WB stage.
- memReqm  in  1  MEM-stage instruction is a load or store.
- dmemAck  in  1  data memory completes the access (1-cycle pulse).
- fwdAe, fwdBe  out  2 each  forwarding select: 00 regfile, 01 WB result, 10 MEM ALU result.
- stallf, stalld, stalle, stallm  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM.
- flushd, flushe, flushw  out  1 each  clear IF/ID, ID/EX, MEM/WB to a bubble.
- dmemReq  out  1  request to data memory.
- memErr  out  1  sticky timeout error.
- stallCnt  out  CNT_W  cycles with stallf asserted.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, dmemReq=0, memErr=0, stallCnt=0, timeout counter=0. Combinational outputs follow their inputs.
- Forwarding (combinational, fwdAe shown; fwdBe identical with rs2e):
  - 10 if regWrtm && rdm!=0 && rdm==rs1e;
  - else 01 if regWrtw && rdw!=0 && rdw==rs1e;
  - else 00.
  - MEM takes priority over WB. x0 never forwards.
- Load-use: lwStall = (rsltSrce==2'b01) && rde!=0 && (rde==rs1d || rde==rs2d).
- memStall = (state==IDLE && memReqm) || (state==WAIT && !dmemAck) || state==ERR.
- Enables:
  - stallf = stalld = lwStall | memStall.
  - stalle = stallm = memStall.
  - flushw = memStall.
  - flushd = pcSrce & ~memStall.
  - flushe = (lwStall | pcSrce) & ~memStall.
  - Branch and load-use in the same cycle: flush wins for ID/EX; IF/ID stalls but is also flushed, and flush has priority in the register.
- Memory FSM:
  - IDLE: memReqm=1 -> WAIT, dmemReq<=1, timeout counter<=0.
  - WAIT: dmemAck=1 -> IDLE, dmemReq<=0. The pipeline advances in this same cycle, so the next memReqm belongs to the next instruction.
  - WAIT: no ack and counter==MEM_TIMEOUT-1 -> ERR, memErr<=1, dmemReq<=0. Otherwise counter+1.
  - ERR: terminal until reset; pipeline held (memStall=1).
  - Minimum access latency is 2 cycles (request registered, ack at earliest the following cycle).
  - dmemAck outside WAIT is ignored.
- stallCnt: +1 per cycle with stallf=1; saturates at all-ones, no wrap.
- Reset mid-access: FSM returns to IDLE immediately, dmemReq drops asynchronously.

Decomposition:
- Shared package (core_pkg) holds:
  - FWD_RF/FWD_WB/FWD_MEM select encodings;
  - RSLT_LOAD=2'b01;
  - the mem_state_t enum (IDLE, WAIT, ERR).
- Natural sub-module: dmem_hs_fsm (FSM, timeout counter, dmemReq, memErr, memStall).
- Forwarding, load-use detection and stallCnt stay in hazard_ctrl.

Test Plan:
- Forwarding: rs1e=5, regWrtm=1, rdm=5, regWrtw=1, rdw=5 -> fwdAe=10. Then rdm=0 -> fwdAe=01. rs2e=0 with rdm=0 -> fwdBe=00.
- Load-use: rsltSrce=01, rde=7, rs2d=7 -> stallf=stalld=flushe=1 for exactly 1 cycle, stallCnt +1. Repeat with rde=0 -> no stall.
- Memory handshake: memReqm=1, dmemAck 3 cycles after dmemReq rises -> dmemReq high 3 cycles, stallm=flushw=1 until the ack cycle, FSM back to IDLE next edge.
- Branch during memory stall: pcSrce=1 while state==WAIT -> flushd=flushe=0 until the ack cycle, then flushd=flushe=1.
- Timeout: MEM_TIMEOUT=4, never ack -> memErr=1 after 4 WAIT cycles, dmemReq=0, stallf stuck at 1. Assert rst_n=0 mid-ERR -> memErr=0, dmemReq=0 asynchronously.
- Saturation: CNT_W=4, hold a memory stall for 20 cycles -> stallCnt=15 and stays there.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings and helpers for the in-order core pipeline control logic.
package core_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_MEM   = 2'b10;
  localparam logic [1:0] RSLT_LOAD = 2'b01;
  localparam int         TO_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_t;

  // Youngest producer (MEM) wins over WB; x0 is hard-wired zero and never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wrt_m,
                                         input logic [4:0] rd_m,
                                         input logic       wrt_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (wrt_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (wrt_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/dmem_hs_fsm.sv
// Data-memory request/acknowledge handshake with timeout and sticky error.
module dmem_hs_fsm
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_req_i,
  input  logic       dmem_ack_i,
  output logic       dmem_req_o,
  output logic       mem_err_o,
  output logic       mem_stall_o,
  output mem_state_t state_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  mem_state_t      state_q, state_d;
  logic            req_q, req_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  // Handshake: dmem_req rises the edge after a MEM-stage access is seen and stays
  // high until the cycle dmem_ack pulses (completion) or the timeout fires; an ack
  // arriving in any other state carries no meaning and is ignored.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          state_d = WAIT;
          req_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (dmem_ack_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
          req_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_stall_o = ((state_q == IDLE) && mem_req_i) ||
                       ((state_q == WAIT) && !dmem_ack_i) ||
                       (state_q == ERR);
  assign dmem_req_o  = req_q;
  assign mem_err_o   = err_q;
  assign state_o     = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forwarding controller for the 5-stage in-order core.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1d,
  input  logic [4:0]       rs2d,
  input  logic [4:0]       rs1e,
  input  logic [4:0]       rs2e,
  input  logic [4:0]       rde,
  input  logic [1:0]       rsltSrce,
  input  logic             pcSrce,
  input  logic             regWrtm,
  input  logic [4:0]       rdm,
  input  logic             regWrtw,
  input  logic [4:0]       rdw,
  input  logic             memReqm,
  input  logic             dmemAck,
  output logic [1:0]       fwdAe,
  output logic [1:0]       fwdBe,
  output logic             stallf,
  output logic             stalld,
  output logic             stalle,
  output logic             stallm,
  output logic             flushd,
  output logic             flushe,
  output logic             flushw,
  output logic             dmemReq,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCnt,
  output mem_state_t       memState
);

  logic             lw_stall;
  logic             mem_stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  dmem_hs_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_dmem_hs (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req_i  (memReqm),
    .dmem_ack_i (dmemAck),
    .dmem_req_o (dmemReq),
    .mem_err_o  (memErr),
    .mem_stall_o(mem_stall),
    .state_o    (memState)
  );

  assign fwdAe = fwd_sel(rs1e, regWrtm, rdm, regWrtw, rdw);
  assign fwdBe = fwd_sel(rs2e, regWrtm, rdm, regWrtw, rdw);

  assign lw_stall = (rsltSrce == RSLT_LOAD) && (rde != 5'd0) &&
                    ((rde == rs1d) || (rde == rs2d));

  // A memory stall freezes the whole pipe, so no flush may destroy held state.
  assign stallf = lw_stall | mem_stall;
  assign stalld = lw_stall | mem_stall;
  assign stalle = mem_stall;
  assign stallm = mem_stall;
  assign flushw = mem_stall;
  assign flushd = pcSrce & ~mem_stall;
  assign flushe = (lw_stall | pcSrce) & ~mem_stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallf && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: expected output vectors are queued at drive time and popped at sample time.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int W           = 19;

  logic             clk;
  logic             rst_n;
  logic [4:0]       rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [1:0]       rsltSrce;
  logic             pcSrce, regWrtm, regWrtw, memReqm, dmemAck;
  logic [1:0]       fwdAe, fwdBe;
  logic             stallf, stalld, stalle, stallm;
  logic             flushd, flushe, flushw;
  logic             dmemReq, memErr;
  logic [CNT_W-1:0] stallCnt;
  mem_state_t       memState;

  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     got, want;
  logic [CNT_W-1:0] sc_exp;
  int               checks;
  int               fails;

  hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs1d    (rs1d),
    .rs2d    (rs2d),
    .rs1e    (rs1e),
    .rs2e    (rs2e),
    .rde     (rde),
    .rsltSrce(rsltSrce),
    .pcSrce  (pcSrce),
    .regWrtm (regWrtm),
    .rdm     (rdm),
    .regWrtw (regWrtw),
    .rdw     (rdw),
    .memReqm (memReqm),
    .dmemAck (dmemAck),
    .fwdAe   (fwdAe),
    .fwdBe   (fwdBe),
    .stallf  (stallf),
    .stalld  (stalld),
    .stalle  (stalle),
    .stallm  (stallm),
    .flushd  (flushd),
    .flushe  (flushe),
    .flushw  (flushw),
    .dmemReq (dmemReq),
    .memErr  (memErr),
    .stallCnt(stallCnt),
    .memState(memState)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: fa fb stallf stalld stalle stallm flushd flushe flushw req err state cnt
  function automatic logic [W-1:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic sf, input logic se, input logic fd,
                                      input logic fe, input logic fw, input logic req,
                                      input logic err, input logic [1:0] st,
                                      input logic [CNT_W-1:0] cnt);
    return {fa, fb, sf, sf, se, se, fd, fe, fw, req, err, st, cnt};
  endfunction

  function automatic logic [W-1:0] observe();
    return {fwdAe, fwdBe, stallf, stalld, stalle, stallm, flushd, flushe, flushw,
            dmemReq, memErr, memState, stallCnt};
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic wm,
                                         input logic [4:0] rm, input logic ww,
                                         input logic [4:0] rw);
    if (wm && rm == rs && rm != 5'd0) return 2'b10;
    if (ww && rw == rs && rw != 5'd0) return 2'b01;
    return 2'b00;
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
    rsltSrce = 2'b00; pcSrce = 0; regWrtm = 0; regWrtw = 0; memReqm = 0; dmemAck = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_model(input logic [W-1:0] w);
    if (w[14] && sc_exp != {CNT_W{1'b1}}) sc_exp = sc_exp + 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    sc_exp = '0;
    #3;
    exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, IDLE, 4'd0));
    got = observe();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL reset: got %h required %h", got, want);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    logic [1:0] fa, fb;
    for (int i = 0; i < 26; i++) begin
      next_cycle();
      case (i)
        0: begin rs1e = 5; rs2e = 0; regWrtm = 1; rdm = 5; regWrtw = 1; rdw = 5; end
        1: rdm = 0;
        2: rs2e = 5;
        3: begin rs1e = 9; rs2e = 9; rdm = 9; rdw = 9; end
        4: regWrtm = 0;
        5: regWrtw = 0;
        default: begin
          rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
          rdm = 5'($urandom_range(0, 3)); rdw = 5'($urandom_range(0, 3));
          regWrtm = 1'($urandom_range(0, 1)); regWrtw = 1'($urandom_range(0, 1));
        end
      endcase
      fa = fwd_ref(rs1e, regWrtm, rdm, regWrtw, rdw);
      fb = fwd_ref(rs2e, regWrtm, rdm, regWrtw, rdw);
      exp_q.push_back(mk(fa, fb, 0, 0, 0, 0, 0, 0, 0, IDLE, sc_exp));
      @(negedge clk);
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL forwarding step %0d: got %h required %h", i, got, want);
      end
      bump_model(want);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      idle_inputs();
      case (i)
        0: begin rsltSrce = 2'b01; rde = 7; rs1d = 3; rs2d = 7;
                 exp_q.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, IDLE, sc_exp)); end
        1: begin rde = 7; rs2d = 7;
                 exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, sc_exp)); end
        2: begin rsltSrce = 2'b01; rde = 0; rs1d = 0; rs2d = 0;
                 exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, sc_exp)); end
        3: begin rsltSrce = 2'b10; rde = 4; rs1d = 4;
                 exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, sc_exp)); end
        4: begin rsltSrce = 2'b01; rde = 4; rs1d = 4; pcSrce = 1;
                 exp_q.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, IDLE, sc_exp)); end
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, sc_exp));
      endcase
      @(negedge clk);
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL load_use step %0d: got %h required %h", i, got, want);
      end
      bump_model(want);
    end
  endtask

  task automatic test_mem_handshake();
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      idle_inputs();
      case (i)
        0: begin memReqm = 1;
                 exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, IDLE, sc_exp)); end
        1, 2: begin memReqm = 1;
                 exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, WAIT, sc_exp)); end
        3: begin memReqm = 1; dmemAck = 1;
                 exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, WAIT, sc_exp)); end
        5: begin dmemAck = 1;
                 exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, sc_exp)); end
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, sc_exp));
      endcase
      @(negedge clk);
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL mem_handshake step %0d: got %h required %h", i, got, want);
      end
      bump_model(want);
    end
  endtask

  task automatic test_branch_during_stall();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      idle_inputs();
      case (i)
        0: begin memReqm = 1;
                 exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, IDLE, sc_exp)); end
        1, 2: begin memReqm = 1; pcSrce = 1;
                 exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, WAIT, sc_exp)); end
        3: begin memReqm = 1; pcSrce = 1; dmemAck = 1;
                 exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, WAIT, sc_exp)); end
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, sc_exp));
      endcase
      @(negedge clk);
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL branch_stall step %0d: got %h required %h", i, got, want);
      end
      bump_model(want);
    end
  endtask

  // Never acknowledge: four WAIT cycles, then ERR held long enough to saturate stallCnt.
  task automatic test_timeout_saturation();
    for (int i = 0; i < 27; i++) begin
      next_cycle();
      idle_inputs();
      if (i == 0) begin
        memReqm = 1;
        exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, IDLE, sc_exp));
      end else if (i <= 4) begin
        memReqm = 1;
        exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, WAIT, sc_exp));
      end else begin
        dmemAck = (i == 6);
        exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 1, ERR, sc_exp));
      end
      @(negedge clk);
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL timeout step %0d: got %h required %h", i, got, want);
      end
      bump_model(want);
    end
  endtask

  task automatic test_reset_mid_err();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      idle_inputs();
      if (i == 0) begin
        #2;
        rst_n = 1'b0;
        sc_exp = '0;
        #1;
      end else begin
        @(negedge clk);
      end
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, sc_exp));
      got = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL reset_mid_err step %0d: got %h required %h", i, got, want);
      end
      if (i == 0) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    sc_exp = '0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_handshake();
    test_branch_during_stall();
    test_timeout_saturation();
    test_reset_mid_err();
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
